// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Holds the default widths, the write-request record and the zero-register index.
package rf_arb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } rf_wr_req_t;

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// N-way round-robin grant; the pointer names the highest-priority requester
// and moves just past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_next;
    logic             found;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (i == (int'(ptr) + k) % N)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    ptr_next = PTR_W'((i + 1) % N);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: writeback has absolute priority, multi-cycle
// units share idle slots round-robin. Optional statistics under RF_WR_STATS_EN.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int N_MC         = 2,
    parameter int ADDR_W       = rf_arb_pkg::ADDR_W,
    parameter int DATA_W       = rf_arb_pkg::DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_rd,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [N_MC-1:0]          mc_valid,
    input  logic [N_MC*ADDR_W-1:0]   mc_rd,
    input  logic [N_MC*DATA_W-1:0]   mc_data,
    output logic [N_MC-1:0]          mc_ready,
    output logic                     stall_pipe,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_rd,
    output logic [DATA_W-1:0]        rf_wdata
`ifdef RF_WR_STATS_EN
    ,
    output logic [31:0]              conflict_cnt,
    output logic [31:0]              starve_cnt
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic             wb_req;
    logic [N_MC-1:0]  mc_req;
    logic             mc_xfer;
    logic             mc_any;
    logic             stall_set;
    logic [CNT_W-1:0] starve_level;
    rf_wr_req_t       mc_sel;
    rf_wr_req_t       wr_next;

    assign wb_req = wb_valid && (wb_rd != REG_ZERO);
    // mc_ready must read zero while reset is held, so the request mask includes reset_n.
    assign mc_req = reset_n ? (mc_valid & {N_MC{!wb_req}}) : '0;

    rr_arbiter #(.N(N_MC)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (mc_req),
        .advance (!wb_req),
        .grant   (mc_ready)
    );

    assign mc_xfer   = |mc_ready;
    assign mc_any    = |mc_valid;
    assign stall_set = (starve_level == CNT_W'(STARVE_LIMIT)) && !mc_xfer;

    always_comb begin
        mc_sel = '0;
        for (int i = 0; i < N_MC; i++) begin
            if (mc_ready[i]) begin
                mc_sel.valid = (mc_rd[i*ADDR_W +: ADDR_W] != REG_ZERO);
                mc_sel.rd    = mc_rd[i*ADDR_W +: ADDR_W];
                mc_sel.data  = mc_data[i*DATA_W +: DATA_W];
            end
        end
        wr_next = wb_req ? '{valid: 1'b1, rd: wb_rd, data: wb_data} : mc_sel;
    end

    // An mc transfer to register 0 is consumed but never raises the write enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= wr_next.valid;
            if (wb_req || mc_xfer) begin
                rf_rd    <= wr_next.rd;
                rf_wdata <= wr_next.data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_level <= '0;
            stall_pipe   <= 1'b0;
        end else begin
            if (mc_xfer || !mc_any) begin
                starve_level <= '0;
            end else if (starve_level != CNT_W'(STARVE_LIMIT)) begin
                starve_level <= starve_level + 1'b1;
            end

            if (mc_xfer) begin
                stall_pipe <= 1'b0;
            end else if (stall_set) begin
                stall_pipe <= 1'b1;
            end
        end
    end

`ifdef RF_WR_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_cnt <= '0;
            starve_cnt   <= '0;
        end else begin
            if (wb_req && mc_any && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
            if (stall_set && !stall_pipe && (starve_cnt != '1)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`endif

    // The pipeline must hold writeback off while stalled; wb still wins if it does not.
    rf_arb_stall_violation: assert property (
        @(posedge clk) disable iff (!reset_n) !(stall_pipe && wb_valid)
    );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected writes are queued when stimulus
// is applied and popped by a monitor when rf_we is seen.
module tb_rf_write_arbiter;

    localparam int N_MC   = 2;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } exp_wr_t;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   wb_valid;
    logic [ADDR_W-1:0]      wb_rd;
    logic [DATA_W-1:0]      wb_data;
    logic [N_MC-1:0]        mc_valid;
    logic [N_MC*ADDR_W-1:0] mc_rd;
    logic [N_MC*DATA_W-1:0] mc_data;
    logic [N_MC-1:0]        mc_ready;
    logic                   stall_pipe;
    logic                   rf_we;
    logic [ADDR_W-1:0]      rf_rd;
    logic [DATA_W-1:0]      rf_wdata;

    int      n_tests = 0;
    int      n_fail  = 0;
    exp_wr_t exp_q[$];

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .N_MC(N_MC), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .mc_valid   (mc_valid),
        .mc_rd      (mc_rd),
        .mc_data    (mc_data),
        .mc_ready   (mc_ready),
        .stall_pipe (stall_pipe),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        mc_valid = '0;
    endtask

    task automatic push(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] data);
        exp_wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every write enable must match the oldest queued write.
    always @(negedge clk) begin
        if (reset_n && rf_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {59'd0, rf_rd}, 64'h1_0000);
            end else begin
                exp_wr_t e;
                e = exp_q.pop_front();
                check("write_rd", 64'(rf_rd), 64'(e.rd));
                check("write_data", 64'(rf_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        idle();
        mc_rd   = '0;
        mc_data = '0;
        mc_valid = 2'b11;
        #2;
        check("reset_rf_we", 64'(rf_we), 64'd0);
        check("reset_rf_rd", 64'(rf_rd), 64'd0);
        check("reset_rf_wdata", 64'(rf_wdata), 64'd0);
        check("reset_stall", 64'(stall_pipe), 64'd0);
        check("reset_mc_ready", 64'(mc_ready), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        idle();
        tick();

        // Writeback with mc idle.
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        #1;
        check("wb_mc_ready", 64'(mc_ready), 64'd0);
        push(5'd3, 32'hDEADBEEF);
        tick();
        idle();
        tick();
        check("wb_drained", 64'(exp_q.size()), 64'd0);

        // Both units held valid: grants alternate 0,1,0,1.
        mc_rd   = {5'd6, 5'd5};
        mc_data = {32'h0000_00B1, 32'h0000_00A0};
        mc_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_grant", 64'(mc_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k % 2 == 0) push(5'd5, 32'h0000_00A0);
            else            push(5'd6, 32'h0000_00B1);
            tick();
        end
        idle();
        tick();
        check("rr_drained", 64'(exp_q.size()), 64'd0);

        // Writeback every cycle blocks mc0 until the starvation guard fires.
        mc_rd   = {5'd0, 5'd17};
        mc_data = {32'h0, 32'h0000_1111};
        for (int k = 1; k <= 5; k++) begin
            wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h100 + 32'(k);
            mc_valid = 2'b01;
            #1;
            check("blocked_mc_ready", 64'(mc_ready), 64'd0);
            check("blocked_stall_low", 64'(stall_pipe), 64'd0);
            push(5'd7, 32'h100 + 32'(k));
            tick();
        end
        check("stall_raised", 64'(stall_pipe), 64'd1);
        wb_valid = 1'b0;
        #1;
        check("stall_mc0_grant", 64'(mc_ready), 64'd1);
        push(5'd17, 32'h0000_1111);
        tick();
        idle();
        check("stall_cleared", 64'(stall_pipe), 64'd0);
        tick();

        // Writeback to r0 frees the slot for mc1 in the same cycle.
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_0000;
        mc_rd   = {5'd9, 5'd0};
        mc_data = {32'h0000_0055, 32'h0};
        mc_valid = 2'b10;
        #1;
        check("wb_r0_mc1_ready", 64'(mc_ready), 64'd2);
        push(5'd9, 32'h0000_0055);
        tick();
        idle();
        tick();

        // mc0 to r0 is consumed but writes nothing.
        mc_rd   = {5'd0, 5'd0};
        mc_data = {32'h0, 32'h0000_0099};
        mc_valid = 2'b01;
        #1;
        check("mc_r0_ready", 64'(mc_ready), 64'd1);
        tick();
        idle();
        check("mc_r0_no_we", 64'(rf_we), 64'd0);
        tick();

        // Build a stall with the pointer at unit 1, then reset mid-stream.
        for (int k = 1; k <= 5; k++) begin
            wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 32'h200 + 32'(k);
            mc_valid = 2'b01;
            push(5'd8, 32'h200 + 32'(k));
            tick();
        end
        idle();
        #1;
        check("pre_reset_stall", 64'(stall_pipe), 64'd1);
        check("pre_reset_rf_we", 64'(rf_we), 64'd1);
        mc_valid = 2'b11;
        reset_n  = 1'b0;
        #1;
        check("async_rf_we", 64'(rf_we), 64'd0);
        check("async_rf_rd", 64'(rf_rd), 64'd0);
        check("async_rf_wdata", 64'(rf_wdata), 64'd0);
        check("async_stall", 64'(stall_pipe), 64'd0);
        check("async_mc_ready", 64'(mc_ready), 64'd0);
        exp_q.delete();
        tick();
        tick();
        idle();
        reset_n = 1'b1;
        tick();
        check("post_reset_no_we", 64'(rf_we), 64'd0);
        mc_rd   = {5'd12, 5'd11};
        mc_data = {32'h0000_CC12, 32'h0000_CC11};
        mc_valid = 2'b11;
        #1;
        check("post_reset_ptr0", 64'(mc_ready), 64'd1);
        push(5'd11, 32'h0000_CC11);
        tick();
        idle();
        tick();
        tick();
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
